// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM stream reader.
package sram_pkg;

    // Read engine command phases.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } rd_state_t;

    // Number of bits needed to represent value (minimum 1).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_stream_reader_if.sv
// Valid/ready stream carrying SRAM words with an end-of-command marker.
interface sram_stream_reader_if #(
    parameter int g_W = 16
);
    logic [g_W-1:0] m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/sram_rd_fifo2.sv
// Two-entry fall-through register FIFO. When empty, the word being pushed
// is presented directly on the output so a read returns to the stream in
// the same cycle it leaves the SRAM; if it is popped right away it is never
// stored. A push while full is only legal together with a pop.
module sram_rd_fifo2 #(
    parameter int g_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           push,
    input  logic [g_W:0]   push_data,
    input  logic           pop,
    output logic [1:0]     count,
    output logic           out_valid,
    output logic [g_W:0]   out_data
);

    logic [g_W:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         do_write;
    logic         do_read;

    // A pushed word bypasses storage only when it is consumed immediately.
    assign do_write  = push && !((cnt == 2'd0) && pop);
    assign do_read   = pop && (cnt != 2'd0);
    assign count     = cnt;
    assign out_valid = (cnt != 2'd0) || push;

    // Head of queue, or the incoming word when empty; zero when nothing is valid.
    always_comb begin
        out_data = '0;
        if (cnt != 2'd0) begin
            out_data = mem[rd_ptr];
        end else if (push) begin
            out_data = push_data;
        end
    end

    // Occupancy and pointer bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            cnt <= cnt + {1'b0, do_write} - {1'b0, do_read};
            if (do_write) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_read) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sram_stream_reader.sv
// Sequential SRAM read engine: a start pulse latches base address and beat
// count, reads are issued on a one-cycle-latency port and the returned words
// leave as a valid/ready stream with m_last on the final beat.
module sram_stream_reader
    import sram_pkg::*;
#(
    parameter int  g_D = 512,
    parameter int  g_W = 16,
    localparam int AW  = clogb2(g_D - 1),
    localparam int LW  = clogb2(g_D)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [LW-1:0]        len,
    output logic                 busy,
    output logic                 done,
    output logic                 ram_en,
    output logic [AW-1:0]        ram_addr,
    input  logic [g_W-1:0]       ram_dout,
    sram_stream_reader_if.master strm
);

    rd_state_t     state;
    logic [AW-1:0] addr;
    logic [LW-1:0] remaining;
    logic          inflight;
    logic          inflight_last;
    logic [1:0]    fifo_count;
    logic          fifo_valid;
    logic [g_W:0]  fifo_out;
    logic          pop;
    logic          room;

    assign pop = strm.m_valid && strm.m_ready;

    // Buffered plus inflight words, less the one leaving now, must stay below
    // two so the word returning next cycle always finds a FIFO slot.
    assign room   = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    assign ram_en = (state == RUN) && (remaining != '0) && room;
    assign ram_addr = addr;

    assign strm.m_valid = fifo_valid;
    assign strm.m_data  = fifo_out[g_W-1:0];
    assign strm.m_last  = fifo_out[g_W];

    sram_rd_fifo2 #(
        .g_W (g_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data ({inflight_last, ram_dout}),
        .pop       (pop),
        .count     (fifo_count),
        .out_valid (fifo_valid),
        .out_data  (fifo_out)
    );

    // Command FSM with address/beat counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= ram_en;
            inflight_last <= ram_en && (remaining == LW'(1));
            if (ram_en) begin
                addr      <= (addr == AW'(g_D - 1)) ? '0 : addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= len;
                        busy      <= 1'b1;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (ram_en && (remaining == LW'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && strm.m_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
